// File: rtl/fmul_36bit_fract_mul.sv
// rtl/fmul_36bit_fract_mul.sv - 36-bit FP multiply front stage: sign, exponent sum, 25x25 mantissa product, flags.
// Optional flush-to-zero of exp==0 operands: define FMUL_36BIT_FRACT_MUL_FTZ_EN.
module fmul_36bit_fract_mul #(
   parameter int EXP_BIAS = 1023
) (
   input  logic        iCLOCK,
   input  logic        inRESET,
   input  logic        iRESET_SYNC,
   input  logic        iDATA_VALID,
   output logic        oDATA_BUSY,
   input  logic [35:0] iDATA_A,
   input  logic [35:0] iDATA_B,
   output logic        oDATA_VALID,
   input  logic        iDATA_BUSY,
   output logic        oDATA_SIGN,
   output logic [12:0] oDATA_EXP,
   output logic [49:0] oDATA_FRACT,
   output logic        oDATA_EXCEPT_EXP_A0,
   output logic        oDATA_EXCEPT_EXP_B0,
   output logic        oDATA_EXCEPT_EXP_A1,
   output logic        oDATA_EXCEPT_EXP_B1,
   output logic        oDATA_EXCEPT_FRACT_A0,
   output logic        oDATA_EXCEPT_FRACT_B0
);

   localparam logic [12:0] BIAS13 = 13'(EXP_BIAS);

   logic [10:0] exp_a, exp_b;
   logic [23:0] fract_a, fract_b;
   logic        exp_a_zero, exp_b_zero;
   logic [24:0] mant_a, mant_b;
   logic        fract_a_zero, fract_b_zero;
   logic [36:0] pp_l;
   logic [37:0] pp_h;
   logic [12:0] exp_sum;
   logic [5:0]  flags;

   assign exp_a      = iDATA_A[34:24];
   assign exp_b      = iDATA_B[34:24];
   assign fract_a    = iDATA_A[23:0];
   assign fract_b    = iDATA_B[23:0];
   assign exp_a_zero = (exp_a == 11'h000);
   assign exp_b_zero = (exp_b == 11'h000);

`ifdef FMUL_36BIT_FRACT_MUL_FTZ_EN
   assign mant_a       = exp_a_zero ? 25'd0 : {1'b1, fract_a};
   assign mant_b       = exp_b_zero ? 25'd0 : {1'b1, fract_b};
   assign fract_a_zero = exp_a_zero | (fract_a == 24'd0);
   assign fract_b_zero = exp_b_zero | (fract_b == 24'd0);
`else
   // exp==0 operands are denormals: no hidden bit, fraction kept as is
   assign mant_a       = {~exp_a_zero, fract_a};
   assign mant_b       = {~exp_b_zero, fract_b};
   assign fract_a_zero = (fract_a == 24'd0);
   assign fract_b_zero = (fract_b == 24'd0);
`endif

   // Split on B so each partial product is a narrower multiplier
   assign pp_l    = {12'd0, mant_a} * {25'd0, mant_b[11:0]};
   assign pp_h    = {13'd0, mant_a} * {25'd0, mant_b[24:12]};
   assign exp_sum = {2'b00, exp_a} + {2'b00, exp_b} - BIAS13;
   assign flags   = {exp_a_zero, exp_b_zero,
                     (exp_a == 11'h7FF), (exp_b == 11'h7FF),
                     fract_a_zero, fract_b_zero};

   assign oDATA_BUSY = iDATA_BUSY;

   logic        s1_valid, s2_valid;
   logic        s1_sign, s2_sign;
   logic [12:0] s1_exp, s2_exp;
   logic [36:0] s1_pp_l;
   logic [37:0] s1_pp_h;
   logic [49:0] s2_fract;
   logic [5:0]  s1_flags, s2_flags;

   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         s1_valid <= 1'b0;
         s1_sign  <= 1'b0;
         s1_exp   <= 13'd0;
         s1_pp_l  <= 37'd0;
         s1_pp_h  <= 38'd0;
         s1_flags <= 6'd0;
         s2_valid <= 1'b0;
         s2_sign  <= 1'b0;
         s2_exp   <= 13'd0;
         s2_fract <= 50'd0;
         s2_flags <= 6'd0;
      end else if (iRESET_SYNC) begin
         s1_valid <= 1'b0;
         s1_sign  <= 1'b0;
         s1_exp   <= 13'd0;
         s1_pp_l  <= 37'd0;
         s1_pp_h  <= 38'd0;
         s1_flags <= 6'd0;
         s2_valid <= 1'b0;
         s2_sign  <= 1'b0;
         s2_exp   <= 13'd0;
         s2_fract <= 50'd0;
         s2_flags <= 6'd0;
      end else if (!iDATA_BUSY) begin
         s1_valid <= iDATA_VALID;
         s1_sign  <= iDATA_A[35] ^ iDATA_B[35];
         s1_exp   <= exp_sum;
         s1_pp_l  <= pp_l;
         s1_pp_h  <= pp_h;
         s1_flags <= flags;
         s2_valid <= s1_valid;
         s2_sign  <= s1_sign;
         s2_exp   <= s1_exp;
         s2_fract <= {13'd0, s1_pp_l} + {s1_pp_h, 12'd0};
         s2_flags <= s1_flags;
      end
   end

   assign oDATA_VALID           = s2_valid;
   assign oDATA_SIGN            = s2_sign;
   assign oDATA_EXP             = s2_exp;
   assign oDATA_FRACT           = s2_fract;
   assign oDATA_EXCEPT_EXP_A0   = s2_flags[5];
   assign oDATA_EXCEPT_EXP_B0   = s2_flags[4];
   assign oDATA_EXCEPT_EXP_A1   = s2_flags[3];
   assign oDATA_EXCEPT_EXP_B1   = s2_flags[2];
   assign oDATA_EXCEPT_FRACT_A0 = s2_flags[1];
   assign oDATA_EXCEPT_FRACT_B0 = s2_flags[0];

endmodule

// File: tb/tb_fmul_36bit_fract_mul.sv
// tb/tb_fmul_36bit_fract_mul.sv - scoreboard bench for fmul_36bit_fract_mul with directed vectors.
module tb_fmul_36bit_fract_mul;

   logic        iCLOCK = 1'b0;
   logic        inRESET = 1'b0;
   logic        iRESET_SYNC = 1'b0;
   logic        iDATA_VALID = 1'b0;
   logic        oDATA_BUSY;
   logic [35:0] iDATA_A = 36'd0;
   logic [35:0] iDATA_B = 36'd0;
   logic        oDATA_VALID;
   logic        iDATA_BUSY = 1'b0;
   logic        oDATA_SIGN;
   logic [12:0] oDATA_EXP;
   logic [49:0] oDATA_FRACT;
   logic        oDATA_EXCEPT_EXP_A0, oDATA_EXCEPT_EXP_B0;
   logic        oDATA_EXCEPT_EXP_A1, oDATA_EXCEPT_EXP_B1;
   logic        oDATA_EXCEPT_FRACT_A0, oDATA_EXCEPT_FRACT_B0;

   fmul_36bit_fract_mul dut (
      .iCLOCK(iCLOCK), .inRESET(inRESET), .iRESET_SYNC(iRESET_SYNC),
      .iDATA_VALID(iDATA_VALID), .oDATA_BUSY(oDATA_BUSY),
      .iDATA_A(iDATA_A), .iDATA_B(iDATA_B),
      .oDATA_VALID(oDATA_VALID), .iDATA_BUSY(iDATA_BUSY),
      .oDATA_SIGN(oDATA_SIGN), .oDATA_EXP(oDATA_EXP), .oDATA_FRACT(oDATA_FRACT),
      .oDATA_EXCEPT_EXP_A0(oDATA_EXCEPT_EXP_A0), .oDATA_EXCEPT_EXP_B0(oDATA_EXCEPT_EXP_B0),
      .oDATA_EXCEPT_EXP_A1(oDATA_EXCEPT_EXP_A1), .oDATA_EXCEPT_EXP_B1(oDATA_EXCEPT_EXP_B1),
      .oDATA_EXCEPT_FRACT_A0(oDATA_EXCEPT_FRACT_A0), .oDATA_EXCEPT_FRACT_B0(oDATA_EXCEPT_FRACT_B0)
   );

   always #5 iCLOCK = ~iCLOCK;

   int n_checks = 0;
   int n_errors = 0;
   logic [69:0] sb[$];

   // {sign, exp13, fract50, exp_a0, exp_b0, exp_a1, exp_b1, fract_a0, fract_b0}
   function automatic logic [69:0] mk(input logic s, input logic [12:0] e,
                                      input logic [49:0] f, input logic [5:0] fl);
      return {s, e, f, fl};
   endfunction

   function automatic logic [69:0] got();
      return {oDATA_SIGN, oDATA_EXP, oDATA_FRACT,
              oDATA_EXCEPT_EXP_A0, oDATA_EXCEPT_EXP_B0,
              oDATA_EXCEPT_EXP_A1, oDATA_EXCEPT_EXP_B1,
              oDATA_EXCEPT_FRACT_A0, oDATA_EXCEPT_FRACT_B0};
   endfunction

   task automatic check(input string name, input logic [69:0] act, input logic [69:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Monitor: compare head of scoreboard whenever a result is presented; pop when consumed
   always @(negedge iCLOCK) begin
      if (inRESET && oDATA_VALID) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_valid: got %h expected no result", got());
         end else begin
            check("result", got(), sb[0]);
            if (!iDATA_BUSY) void'(sb.pop_front());
         end
      end
   end

   task automatic cyc(input logic v, input logic [35:0] a, input logic [35:0] b,
                      input logic busy, input logic [69:0] e);
      iDATA_VALID = v;
      iDATA_A     = a;
      iDATA_B     = b;
      iDATA_BUSY  = busy;
      @(posedge iCLOCK);
      if (v && !busy) sb.push_back(e);
      #1;
   endtask

   task automatic drain();
      int k;
      iDATA_VALID = 1'b0;
      iDATA_BUSY  = 1'b0;
      k = 0;
      while (sb.size() != 0 && k < 50) begin
         @(posedge iCLOCK);
         #1;
         k++;
      end
      n_checks++;
      if (sb.size() != 0) begin
         n_errors++;
         $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
      end
   endtask

   localparam logic [35:0] ONE  = 36'h3FF000000;
   localparam logic [49:0] P48  = 50'h1000000000000;
   logic [69:0] e_den;

   initial begin
`ifdef FMUL_36BIT_FRACT_MUL_FTZ_EN
      e_den = mk(1'b0, 13'h0000, 50'h0, 6'b100011);
`else
      // 2^22 * 2^24 = 2^46
      e_den = mk(1'b0, 13'h0000, 50'h0400000000000, 6'b100001);
`endif
      repeat (2) @(posedge iCLOCK);
      #1;
      check("reset_outputs", {69'd0, oDATA_VALID} | got(), 70'd0);
      inRESET = 1'b1;
      @(posedge iCLOCK);
      #1;

      // Back-to-back directed vectors, then a bubble
      cyc(1, ONE, ONE, 0, mk(0, 13'h03FF, P48, 6'b000011));
      cyc(1, 36'h3FF800000, 36'hBFF800000, 0, mk(1, 13'h03FF, 50'h2400000000000, 6'b000000));
      cyc(1, 36'h3FFFFFFFF, 36'h3FFFFFFFF, 0, mk(0, 13'h03FF, 50'h3FFFFFC000001, 6'b000000));
      cyc(1, 36'h001000000, 36'h001000000, 0, mk(0, 13'h1C03, P48, 6'b000011));
      cyc(0, 36'h0, 36'h0, 0, 70'd0);
      cyc(1, 36'h7FF000000, ONE, 0, mk(0, 13'h07FF, P48, 6'b001011));
      cyc(1, 36'h000400000, ONE, 0, e_den);
      cyc(1, 36'hC00000000, 36'hBFF800000, 0, mk(0, 13'h0400, 50'h1800000000000, 6'b000010));
      cyc(1, 36'h7FFFFFFFF, 36'h7FFFFFFFF, 0, mk(0, 13'h0BFF, 50'h3FFFFFC000001, 6'b001100));
      cyc(1, 36'h000000000, 36'h800000000, 0, mk(1, 13'h1C01, 50'h0, 6'b110011));
      cyc(1, 36'h3FF000FFF, ONE, 0, mk(0, 13'h03FF, 50'h1000FFF000000, 6'b000001));
      cyc(1, ONE, 36'h3FF000FFF, 0, mk(0, 13'h03FF, 50'h1000FFF000000, 6'b000010));
      drain();

      // Stall for two cycles mid-stream with op3 held on the inputs
      cyc(1, ONE, ONE, 0, mk(0, 13'h03FF, P48, 6'b000011));
      cyc(1, 36'h3FF800000, 36'hBFF800000, 0, mk(1, 13'h03FF, 50'h2400000000000, 6'b000000));
      cyc(1, 36'h3FFFFFFFF, 36'h3FFFFFFFF, 1, 70'd0);
      cyc(1, 36'h3FFFFFFFF, 36'h3FFFFFFFF, 1, 70'd0);
      cyc(1, 36'h3FFFFFFFF, 36'h3FFFFFFFF, 0, mk(0, 13'h03FF, 50'h3FFFFFC000001, 6'b000000));
      drain();

      // Sync clear wins over a stall; the in-flight op must never appear
      cyc(1, ONE, ONE, 0, mk(0, 13'h03FF, P48, 6'b000011));
      iDATA_VALID = 1'b0;
      iDATA_BUSY  = 1'b1;
      iRESET_SYNC = 1'b1;
      @(posedge iCLOCK);
      sb.delete();
      #1;
      iRESET_SYNC = 1'b0;
      iDATA_BUSY  = 1'b0;
      check("sync_clear", {69'd0, oDATA_VALID} | got(), 70'd0);
      repeat (4) @(posedge iCLOCK);
      #1;

      // Async reset with a result on the outputs clears without a clock edge
      cyc(1, 36'h3FF800000, 36'hBFF800000, 0, mk(1, 13'h03FF, 50'h2400000000000, 6'b000000));
      cyc(0, 36'h0, 36'h0, 0, 70'd0);
      #1;
      inRESET = 1'b0;
      #1;
      check("async_reset", {69'd0, oDATA_VALID} | got(), 70'd0);
      sb.delete();
      #1;
      inRESET = 1'b1;
      repeat (3) @(posedge iCLOCK);
      #1;

      cyc(1, ONE, ONE, 0, mk(0, 13'h03FF, P48, 6'b000011));
      drain();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
